// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-pipe result FIFOs drained round-robin onto NUM_WB
// register-file write / ROB completion ports, with flush, stall and overflow.

package writeback_arbiter_pkg;
    localparam int PRD_W = 6;
    localparam int ROB_W = 6;

    typedef struct packed {
        logic             valid;
        logic             rd_valid;
        logic [PRD_W-1:0] prd;
        logic [ROB_W-1:0] rob_idx;
    } micro_op_t;
endpackage

module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int NUM_PIPES = 3,
    parameter int NUM_WB    = 2,
    parameter int DEPTH     = 4,
    parameter int PRF_W     = 6
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  micro_op_t [NUM_PIPES-1:0]         uop_in,
    input  logic      [NUM_PIPES-1:0][31:0]   data_in,
    output logic      [NUM_PIPES-1:0]         pipe_stall,
    output logic      [NUM_WB-1:0]            wb_valid,
    output logic      [NUM_WB-1:0]            wb_we,
    output logic      [NUM_WB-1:0][PRF_W-1:0] wb_prd,
    output logic      [NUM_WB-1:0][31:0]      wb_data,
    output micro_op_t [NUM_WB-1:0]            wb_uop,
    output logic                              overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RR_W  = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

    micro_op_t        r_mem_uop  [NUM_PIPES][DEPTH];
    logic [31:0]      r_mem_data [NUM_PIPES][DEPTH];
    logic [PTR_W-1:0] r_rd_ptr   [NUM_PIPES];
    logic [PTR_W-1:0] r_wr_ptr   [NUM_PIPES];
    logic [CNT_W-1:0] r_count    [NUM_PIPES];
    logic [RR_W-1:0]  r_rr;

    logic [NUM_PIPES-1:0] w_pop;
    logic [NUM_PIPES-1:0] w_push;
    logic [NUM_PIPES-1:0] w_full;
    logic [NUM_PIPES-1:0] w_accept;
    logic [NUM_PIPES-1:0] w_drop;
    logic [NUM_WB-1:0]    w_gnt_valid;
    logic [RR_W-1:0]      w_gnt_pipe  [NUM_WB];
    micro_op_t            w_head_uop  [NUM_WB];
    logic [31:0]          w_head_data [NUM_WB];
    logic [RR_W-1:0]      w_rr_next;

    // Round-robin scan from r_rr; the k-th non-empty FIFO found goes to port k.
    // NOTE: every combinational output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        int idx;
        int n_gnt;
        w_pop       = '0;
        w_gnt_valid = '0;
        w_rr_next   = r_rr;
        n_gnt       = 0;
        idx         = 0;
        for (int k = 0; k < NUM_WB; k++) begin
            w_gnt_pipe[k] = '0;
        end
        for (int j = 0; j < NUM_PIPES; j++) begin
            idx = (int'(r_rr) + j) % NUM_PIPES;
            if (r_count[idx] != '0 && n_gnt < NUM_WB) begin
                w_pop[idx]         = 1'b1;
                w_gnt_valid[n_gnt] = 1'b1;
                w_gnt_pipe[n_gnt]  = RR_W'(idx);
                w_rr_next          = RR_W'((idx + 1) % NUM_PIPES);
                n_gnt              = n_gnt + 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_WB; k++) begin
            w_head_uop[k]  = r_mem_uop[w_gnt_pipe[k]][r_rd_ptr[w_gnt_pipe[k]]];
            w_head_data[k] = r_mem_data[w_gnt_pipe[k]][r_rd_ptr[w_gnt_pipe[k]]];
        end
    end

    // A full FIFO still accepts when its head leaves in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_PIPES; i++) begin
            w_full[i]     = (r_count[i] == CNT_W'(DEPTH));
            w_push[i]     = uop_in[i].valid && !flush;
            w_accept[i]   = w_push[i] && (!w_full[i] || w_pop[i]);
            w_drop[i]     = w_push[i] && w_full[i] && !w_pop[i];
            pipe_stall[i] = (r_count[i] >= CNT_W'(DEPTH - 2));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rr <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            r_rr <= w_rr_next;
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                end
                if (w_accept[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                end
                r_count[i] <= r_count[i] + CNT_W'(w_accept[i]) - CNT_W'(w_pop[i]);
            end
        end
    end

    // NOTE: payload storage is not reset; counts and pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (w_accept[i] && !reset) begin
                r_mem_uop[i][r_wr_ptr[i]]  <= uop_in[i];
                r_mem_data[i][r_wr_ptr[i]] <= data_in[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_WB; k++) begin
            if (reset || flush || !w_gnt_valid[k]) begin
                wb_valid[k] <= 1'b0;
                wb_we[k]    <= 1'b0;
                wb_prd[k]   <= '0;
                wb_data[k]  <= '0;
                wb_uop[k]   <= '0;
            end else begin
                wb_valid[k] <= 1'b1;
                wb_we[k]    <= w_head_uop[k].rd_valid;
                wb_prd[k]   <= PRF_W'(w_head_uop[k].prd);
                wb_data[k]  <= w_head_data[k];
                wb_uop[k]   <= w_head_uop[k];
            end
        end
    end

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (|w_drop) begin
            overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: latency, round-robin order, stall,
// overflow with per-pipe ordering, branch writeback, flush and reset.

module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int NP    = 3;
    localparam int NW    = 2;
    localparam int DEPTH = 4;
    localparam int PRF_W = 6;

    logic                         clock = 1'b0;
    logic                         reset;
    logic                         flush;
    micro_op_t [NP-1:0]           uop_in;
    logic      [NP-1:0][31:0]     data_in;
    logic      [NP-1:0]           pipe_stall;
    logic      [NW-1:0]           wb_valid;
    logic      [NW-1:0]           wb_we;
    logic      [NW-1:0][PRF_W-1:0] wb_prd;
    logic      [NW-1:0][31:0]     wb_data;
    micro_op_t [NW-1:0]           wb_uop;
    logic                         overflow;

    int n_checks  = 0;
    int n_pass    = 0;
    int p1_expect = 1;
    bit mon_en    = 1'b0;

    writeback_arbiter #(
        .NUM_PIPES(NP), .NUM_WB(NW), .DEPTH(DEPTH), .PRF_W(PRF_W)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .uop_in(uop_in), .data_in(data_in), .pipe_stall(pipe_stall),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_prd(wb_prd),
        .wb_data(wb_data), .wb_uop(wb_uop), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end else begin
            n_pass++;
        end
    endtask

    // One clock edge, then sample 1 time unit later; optionally track pipe-1 order.
    task automatic step();
        @(posedge clock);
        #1;
        if (mon_en) begin
            for (int k = 0; k < NW; k++) begin
                if (wb_valid[k] && wb_data[k][31:16] == 16'hA001) begin
                    check("order_p1", 64'(wb_data[k]), 64'(32'hA001_0000 + p1_expect));
                    p1_expect++;
                end
            end
        end
    endtask

    task automatic clear_inputs();
        uop_in  = '0;
        data_in = '0;
    endtask

    task automatic set_pipe(input int p, input logic rdv, input logic [5:0] prd, input logic [31:0] d);
        uop_in[p]  = '{valid: 1'b1, rd_valid: rdv, prd: prd, rob_idx: ROB_W'(p)};
        data_in[p] = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        flush = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        micro_op_t exp_u;
        logic [NW-1:0] seen;

        clear_inputs();
        flush = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_valid", 64'(wb_valid), 64'(0));
        check("rst_stall", 64'(pipe_stall), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));

        // Single ALU result: visible after the second edge, port 1 idle.
        set_pipe(0, 1'b1, 6'd5, 32'h1234);
        step();
        check("no_bypass", 64'(wb_valid), 64'(0));
        clear_inputs();
        step();
        check("single_valid", 64'(wb_valid), 64'(2'b01));
        check("single_we", 64'(wb_we), 64'(2'b01));
        check("single_prd", 64'(wb_prd), 64'({6'd0, 6'd5}));
        check("single_data", 64'(wb_data), {32'h0, 32'h1234});
        step();
        check("single_done", 64'(wb_valid), 64'(0));

        // All three pipes at once from rr=0.
        do_reset();
        set_pipe(0, 1'b1, 6'd10, 32'hA0);
        set_pipe(1, 1'b1, 6'd11, 32'hA1);
        set_pipe(2, 1'b1, 6'd12, 32'hA2);
        step();
        clear_inputs();
        step();
        check("rr_first_valid", 64'(wb_valid), 64'(2'b11));
        check("rr_first_prd", 64'(wb_prd), 64'({6'd11, 6'd10}));
        check("rr_first_data", 64'(wb_data), {32'hA1, 32'hA0});
        step();
        check("rr_second_valid", 64'(wb_valid), 64'(2'b01));
        check("rr_second_prd", 64'(wb_prd[0]), 64'(12));
        // rr must now be 0: pipes 0 and 2 together land on ports 0 and 1 in that order.
        step();
        set_pipe(0, 1'b1, 6'd20, 32'hB0);
        set_pipe(2, 1'b1, 6'd22, 32'hB2);
        step();
        clear_inputs();
        step();
        check("rr_wrap_prd", 64'(wb_prd), 64'({6'd22, 6'd20}));

        // Branch uop: completes without a register write.
        set_pipe(1, 1'b0, 6'd7, 32'h77);
        step();
        clear_inputs();
        step();
        exp_u = '{valid: 1'b1, rd_valid: 1'b0, prd: 6'd7, rob_idx: 6'd1};
        check("branch_valid", 64'(wb_valid), 64'(2'b01));
        check("branch_we", 64'(wb_we), 64'(0));
        check("branch_uop", 64'(wb_uop[0]), 64'(exp_u));

        // Saturation: all pipes fed (pipe 2 stops after edge 10); pipe 1 overflows at edge 12.
        do_reset();
        mon_en    = 1'b1;
        p1_expect = 1;
        for (int n = 1; n <= 12; n++) begin
            clear_inputs();
            set_pipe(0, 1'b1, 6'd1, 32'hA000_0000 + 32'(n));
            set_pipe(1, 1'b1, 6'd2, 32'hA001_0000 + 32'(n));
            if (n <= 10) set_pipe(2, 1'b1, 6'd3, 32'hA002_0000 + 32'(n));
            step();
            if (n == 2) check("stall_e2", 64'(pipe_stall), 64'(3'b100));
            if (n == 3) check("stall_e3", 64'(pipe_stall), 64'(3'b110));
            if (n == 4) check("stall_e4", 64'(pipe_stall), 64'(3'b111));
            if (n == 11) check("ovf_before", 64'(overflow), 64'(0));
            if (n == 12) check("ovf_set", 64'(overflow), 64'(1));
        end
        clear_inputs();
        for (int n = 0; n < 20; n++) step();
        mon_en = 1'b0;
        check("p1_drained", 64'(p1_expect), 64'(12));
        check("drain_idle", 64'(wb_valid), 64'(0));
        check("ovf_sticky", 64'(overflow), 64'(1));

        // Flush with 3 buffered entries and a new valid input in the same cycle.
        do_reset();
        set_pipe(0, 1'b1, 6'd1, 32'hC0);
        set_pipe(1, 1'b1, 6'd2, 32'hC1);
        set_pipe(2, 1'b1, 6'd3, 32'hC2);
        step();
        clear_inputs();
        set_pipe(0, 1'b1, 6'd4, 32'hDEAD);
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_inputs();
        check("flush_valid", 64'(wb_valid), 64'(0));
        check("flush_stall", 64'(pipe_stall), 64'(0));
        seen = '0;
        for (int n = 0; n < 4; n++) begin
            step();
            seen = seen | wb_valid;
        end
        check("flush_nothing_out", 64'(seen), 64'(0));

        // Reset with full FIFOs and overflow set, inputs still active.
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            set_pipe(0, 1'b1, 6'd1, 32'hB000_0000 + 32'(n));
            set_pipe(1, 1'b1, 6'd2, 32'hB001_0000 + 32'(n));
            set_pipe(2, 1'b1, 6'd3, 32'hB002_0000 + 32'(n));
            step();
        end
        check("pre_rst_ovf", 64'(overflow), 64'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        check("mid_rst_valid", 64'(wb_valid), 64'(0));
        check("mid_rst_we", 64'(wb_we), 64'(0));
        check("mid_rst_prd", 64'(wb_prd), 64'(0));
        check("mid_rst_data", 64'(wb_data), 64'(0));
        check("mid_rst_uop", 64'(wb_uop), 64'(0));
        check("mid_rst_ovf", 64'(overflow), 64'(0));
        check("mid_rst_stall", 64'(pipe_stall), 64'(0));
        seen = '0;
        for (int n = 0; n < 3; n++) begin
            step();
            seen = seen | wb_valid;
        end
        check("mid_rst_discard", 64'(seen), 64'(0));
        set_pipe(1, 1'b1, 6'd9, 32'h55);
        step();
        clear_inputs();
        step();
        check("post_rst_valid", 64'(wb_valid), 64'(2'b01));
        check("post_rst_prd", 64'(wb_prd[0]), 64'(9));
        check("post_rst_data", 64'(wb_data[0]), 64'(32'h55));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
